mem_arbiter: RTL

- Shares one mem_system (cache plus four-bank memory) between the instruction-fetch port and the data-memory port of the pipeline.
- Accepts requests from both ports and grants one at a time, round-robin on contention.
- Latches the winner's address, data and operation, then holds rd/wr to mem_system until done.
- Routes done, data and error back to the owner only; stalls the other port; runs a watchdog on every transaction.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arb_statereg.sv | 21 ++
 rtl/mem_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state/owner encodings and defaults shared by the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_HALT    = 2'd3
    } state_t;
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and mem_system signal bundle
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_out;
    logic              i_done;
    logic              i_stall;
    logic              i_err;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic [DATA_W-1:0] d_data_out;
    logic              d_done;
    logic              d_stall;
    logic              d_err;
    logic              m_rd;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data_in;
    logic [DATA_W-1:0] m_data_out;
    logic              m_done;
    logic              m_err;
    modport slave (
        input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_err,
        output i_data_out, i_done, i_stall, i_err, d_data_out, d_done, d_stall, d_err,
               m_rd, m_wr, m_addr, m_data_in
    );
    modport master (
        output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_err,
        input  i_data_out, i_done, i_stall, i_err, d_data_out, d_done, d_stall, d_err,
               m_rd, m_wr, m_addr, m_data_in
    );
endinterface

// File: rtl/mem_arb_statereg.sv
// mem_arb_statereg: arbiter state flop and round-robin last-owner flop
module mem_arb_statereg
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  state_t state_d,
    input  owner_t last_d,
    output state_t state_q,
    output owner_t last_q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= OWN_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between the fetch and data ports, round-robin on contention
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    state_t            state_q, state_d;
    owner_t            last_q, last_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic              serve, srv_i, srv_d, halt, idle, illegal, d_req, grant_d, timeout, ok;
    mem_arb_statereg u_statereg (
        .clk     (clk),
        .rst     (rst),
        .state_d (state_d),
        .last_d  (last_d),
        .state_q (state_q),
        .last_q  (last_q)
    );
    assign idle    = state_q == ST_IDLE;
    assign srv_i   = state_q == ST_SERVE_I;
    assign srv_d   = state_q == ST_SERVE_D;
    assign halt    = state_q == ST_HALT;
    assign serve   = srv_i | srv_d;
    assign illegal = bus.d_rd & bus.d_wr;
    assign d_req   = bus.d_rd ^ bus.d_wr;
    assign grant_d = d_req & (~bus.i_rd | (last_q == OWN_I));
    assign timeout = serve & ~bus.m_done & (wdog_q == WD_LAST);
    assign ok      = bus.m_done & ~bus.m_err;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: if (bus.i_rd | d_req) begin
                state_d = grant_d ? ST_SERVE_D : ST_SERVE_I;
                last_d  = grant_d ? OWN_D : OWN_I;
                wdog_d  = '0;
                addr_d  = grant_d ? bus.d_addr : bus.i_addr;
                data_d  = grant_d ? bus.d_data_in : '0;
                wr_d    = grant_d & bus.d_wr;
            end
            ST_SERVE_I, ST_SERVE_D: begin
                wdog_d  = (bus.m_done | (wdog_q == '1)) ? wdog_q : wdog_q + WD_W'(1);
                state_d = (bus.m_err | bus.m_done) ? ST_IDLE : timeout ? ST_HALT : state_q;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wr_q   <= wr_d;
        end
    end
    assign bus.m_rd       = serve & ~wr_q;
    assign bus.m_wr       = serve & wr_q;
    assign bus.m_addr     = serve ? addr_q : '0;
    assign bus.m_data_in  = serve ? data_q : '0;
    assign bus.i_done     = srv_i & ok;
    assign bus.d_done     = srv_d & ok;
    assign bus.i_data_out = bus.i_done ? bus.m_data_out : '0;
    assign bus.d_data_out = bus.d_done ? bus.m_data_out : '0;
    assign bus.i_err      = halt | (srv_i & (bus.m_err | timeout));
    // rst gates the illegal-op pulse so every err output reads 0 while held in reset
    assign bus.d_err      = halt | (srv_d & (bus.m_err | timeout)) | (idle & illegal & rst);
    assign bus.i_stall    = halt | (bus.i_rd & ~bus.i_done);
    assign bus.d_stall    = halt | ((bus.d_rd | bus.d_wr) & ~bus.d_done);
endmodule
